// File: rtl/dds_ctrl_regs_pkg.sv
// Shared encodings for the DDS parameter controller.
// Pure declarations: no latency, no state.
// No flow control; consumed by the controller and its button sequencer.
package dds_ctrl_regs_pkg;

  // Waveform shape codes seen by the DDS core (3 is never produced).
  typedef enum logic [1:0] {
    SHAPE_SIN = 2'd0,
    SHAPE_TRI = 2'd1,
    SHAPE_SQR = 2'd2
  } shape_e;

  // Field currently selected for editing.
  typedef enum logic [1:0] {
    SEL_PHASE = 2'd0,
    SEL_AMP   = 2'd1,
    SEL_SHAPE = 2'd2,
    SEL_NONE  = 2'd3
  } sel_e;

  // Button auto-repeat sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DLY  = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  // Cycle through the shapes: up goes sin->tri->sqr->sin, down goes the other way.
  function automatic logic [1:0] shape_next(input logic [1:0] cur, input logic up);
    case (cur)
      SHAPE_SIN: return up ? SHAPE_TRI : SHAPE_SQR;
      SHAPE_TRI: return up ? SHAPE_SQR : SHAPE_SIN;
      SHAPE_SQR: return up ? SHAPE_SIN : SHAPE_TRI;
      default:   return SHAPE_SIN;
    endcase
  endfunction

endpackage

// File: rtl/dds_ctrl_regs_if.sv
// Bundle between the parameter controller and its environment (buttons, selectors, DDS core).
// No latency: wires only.
// Update handshake is valid/ready; upd_valid holds until upd_ready is seen.
interface dds_ctrl_regs_if #(
  parameter int NCH     = 2,
  parameter int PHASE_W = 11,
  parameter int AMP_W   = 11
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                     btn_up;
  logic                     btn_down;
  logic [1:0]               sel_param;
  logic [CH_W-1:0]          sel_ch;
  logic [NCH*PHASE_W-1:0]   phase_M;
  logic [NCH*AMP_W-1:0]     signal_A;
  logic [NCH*2-1:0]         signal_shape;
  logic                     upd_valid;
  logic                     upd_ready;

  // The controller drives the committed snapshot and upd_valid.
  modport master (
    input  btn_up, btn_down, sel_param, sel_ch, upd_ready,
    output phase_M, signal_A, signal_shape, upd_valid
  );

  // Environment side: buttons/selectors in, snapshot consumed by the DDS core.
  modport slave (
    output btn_up, btn_down, sel_param, sel_ch, upd_ready,
    input  phase_M, signal_A, signal_shape, upd_valid
  );
endinterface

// File: rtl/dds_ctrl_regs_btn_repeat.sv
// Turns held up/down buttons into step pulses: one at press, then auto-repeat.
// Step pulse is combinational in the press cycle; repeat steps follow the hold counter.
// No backpressure: steps are always consumed by the register file.
module dds_ctrl_regs_btn_repeat
  import dds_ctrl_regs_pkg::*;
#(
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_i,
  input  logic btn_down_i,
  output logic step_pulse_o,
  output logic step_dir_o
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

  rpt_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic             act;
  logic             hold_ok;

  // Exactly one button pressed counts as activity; a direction swap breaks the hold.
  assign act        = btn_up_i ^ btn_down_i;
  assign hold_ok    = act && (btn_up_i == dir_q);
  assign step_dir_o = btn_up_i;

  // Step on the press itself and whenever the hold counter hits its terminal count.
  always_comb begin
    step_pulse_o = 1'b0;
    case (state_q)
      ST_IDLE: step_pulse_o = act;
      ST_DLY:  step_pulse_o = hold_ok && (cnt_q == DLY_LAST);
      ST_RPT:  step_pulse_o = hold_ok && (cnt_q == PER_LAST);
      default: step_pulse_o = 1'b0;
    endcase
  end

  // Hold sequencer: initial delay, then periodic repeat until release or swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (act) begin
            state_q <= ST_DLY;
            dir_q   <= btn_up_i;
          end
        end
        ST_DLY: begin
          if (!hold_ok) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DLY_LAST) begin
            state_q <= ST_RPT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RPT: begin
          if (!hold_ok) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == PER_LAST) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dds_ctrl_regs.sv
// Per-channel DDS parameters: button-edited working set, committed snapshot to the core.
// Step lands in the working set one cycle later; committed set loads on accept.
// upd_valid holds until upd_ready; a same-cycle changing step keeps it asserted.
module dds_ctrl_regs
  import dds_ctrl_regs_pkg::*;
#(
  parameter int PHASE_W    = 11,
  parameter int AMP_W      = 11,
  parameter int NCH        = 2,
  parameter int PHASE_DEF  = 500,
  parameter int AMP_DEF    = 1200,
  parameter int AMP_MAX    = 2047,
  parameter int PHASE_STEP = 10,
  parameter int AMP_STEP   = 50,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input logic             clk,
  input logic             rst,
  dds_ctrl_regs_if.master bus
);

  localparam logic [PHASE_W:0] PH_MAX_X  = {1'b0, {PHASE_W{1'b1}}};
  localparam logic [PHASE_W:0] PH_STEP_X = (PHASE_W + 1)'(PHASE_STEP);
  localparam logic [AMP_W:0]   AM_MAX_X  = (AMP_W + 1)'(AMP_MAX);
  localparam logic [AMP_W:0]   AM_STEP_X = (AMP_W + 1)'(AMP_STEP);

  logic step_pulse;
  logic step_dir;

  logic [PHASE_W-1:0] wrk_phase_q [NCH];
  logic [PHASE_W-1:0] wrk_phase_d [NCH];
  logic [AMP_W-1:0]   wrk_amp_q   [NCH];
  logic [AMP_W-1:0]   wrk_amp_d   [NCH];
  logic [1:0]         wrk_shape_q [NCH];
  logic [1:0]         wrk_shape_d [NCH];
  logic [PHASE_W-1:0] cmt_phase_q [NCH];
  logic [AMP_W-1:0]   cmt_amp_q   [NCH];
  logic [1:0]         cmt_shape_q [NCH];

  logic any_chg;
  logic accept;
  logic upd_valid_q;
  logic upd_valid_d;

  dds_ctrl_regs_btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_btn (
    .clk          (clk),
    .rst          (rst),
    .btn_up_i     (bus.btn_up),
    .btn_down_i   (bus.btn_down),
    .step_pulse_o (step_pulse),
    .step_dir_o   (step_dir)
  );

  // Saturating edit of the selected field; out-of-range channel or SEL_NONE edits nothing.
  always_comb begin
    logic [PHASE_W:0] ph_x;
    logic [AMP_W:0]   am_x;
    ph_x    = '0;
    am_x    = '0;
    any_chg = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      wrk_phase_d[k] = wrk_phase_q[k];
      wrk_amp_d[k]   = wrk_amp_q[k];
      wrk_shape_d[k] = wrk_shape_q[k];
      if (step_pulse && (32'(bus.sel_ch) == k)) begin
        case (bus.sel_param)
          SEL_PHASE: begin
            if (step_dir) begin
              ph_x = {1'b0, wrk_phase_q[k]} + PH_STEP_X;
              if (ph_x > PH_MAX_X) ph_x = PH_MAX_X;
            end else if ({1'b0, wrk_phase_q[k]} < PH_STEP_X) begin
              ph_x = '0;
            end else begin
              ph_x = {1'b0, wrk_phase_q[k]} - PH_STEP_X;
            end
            wrk_phase_d[k] = ph_x[PHASE_W-1:0];
          end
          SEL_AMP: begin
            if (step_dir) begin
              am_x = {1'b0, wrk_amp_q[k]} + AM_STEP_X;
              if (am_x > AM_MAX_X) am_x = AM_MAX_X;
            end else if ({1'b0, wrk_amp_q[k]} < AM_STEP_X) begin
              am_x = '0;
            end else begin
              am_x = {1'b0, wrk_amp_q[k]} - AM_STEP_X;
            end
            wrk_amp_d[k] = am_x[AMP_W-1:0];
          end
          SEL_SHAPE: wrk_shape_d[k] = shape_next(wrk_shape_q[k], step_dir);
          default:   ;
        endcase
      end
    end
    // A step pinned at a clamp leaves the set unchanged and must not raise upd_valid.
    for (int k = 0; k < NCH; k++) begin
      if ((wrk_phase_d[k] != wrk_phase_q[k]) || (wrk_amp_d[k] != wrk_amp_q[k]) ||
          (wrk_shape_d[k] != wrk_shape_q[k])) begin
        any_chg = 1'b1;
      end
    end
  end

  // Handshake: accept drops valid unless a fresh change arrives in the same cycle.
  assign accept      = upd_valid_q && bus.upd_ready;
  assign upd_valid_d = any_chg || (upd_valid_q && !accept);

  // Working set follows edits; committed set snapshots the pre-edit working set on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        wrk_phase_q[k] <= PHASE_W'(PHASE_DEF);
        wrk_amp_q[k]   <= AMP_W'(AMP_DEF);
        wrk_shape_q[k] <= SHAPE_SIN;
        cmt_phase_q[k] <= PHASE_W'(PHASE_DEF);
        cmt_amp_q[k]   <= AMP_W'(AMP_DEF);
        cmt_shape_q[k] <= SHAPE_SIN;
      end
      upd_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        wrk_phase_q[k] <= wrk_phase_d[k];
        wrk_amp_q[k]   <= wrk_amp_d[k];
        wrk_shape_q[k] <= wrk_shape_d[k];
        if (accept) begin
          cmt_phase_q[k] <= wrk_phase_q[k];
          cmt_amp_q[k]   <= wrk_amp_q[k];
          cmt_shape_q[k] <= wrk_shape_q[k];
        end
      end
      upd_valid_q <= upd_valid_d;
    end
  end

  // Pack the committed arrays onto the flat buses, channel k at slice k.
  always_comb begin
    bus.phase_M      = '0;
    bus.signal_A     = '0;
    bus.signal_shape = '0;
    for (int k = 0; k < NCH; k++) begin
      bus.phase_M[k*PHASE_W +: PHASE_W] = cmt_phase_q[k];
      bus.signal_A[k*AMP_W +: AMP_W]    = cmt_amp_q[k];
      bus.signal_shape[k*2 +: 2]        = cmt_shape_q[k];
    end
  end

  assign bus.upd_valid = upd_valid_q;

endmodule

// File: tb/tb_dds_ctrl_regs.sv
// Bench for dds_ctrl_regs: directed vector table, hand-written corner sequences,
// then randomized button/selector/ready traffic against a behavioural model.
module tb_dds_ctrl_regs;
  import dds_ctrl_regs_pkg::*;

  localparam int NCH   = 2;
  localparam int PW    = 11;
  localparam int AW    = 11;
  localparam int RD    = 8;
  localparam int RP    = 4;
  localparam int PDEF  = 500;
  localparam int ADEF  = 1200;
  localparam int AMAX  = 2047;
  localparam int PMAX  = 2047;
  localparam int PSTEP = 10;
  localparam int ASTEP = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_ctrl_regs_if #(.NCH(NCH), .PHASE_W(PW), .AMP_W(AW)) bus ();

  dds_ctrl_regs #(
    .PHASE_W(PW), .AMP_W(AW), .NCH(NCH), .PHASE_DEF(PDEF), .AMP_DEF(ADEF),
    .AMP_MAX(AMAX), .PHASE_STEP(PSTEP), .AMP_STEP(ASTEP),
    .REPEAT_DLY(RD), .REPEAT_PER(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;

  // Behavioural reference: working/committed values, pending flag, hold length.
  int m_wph [NCH];
  int m_wam [NCH];
  int m_wsh [NCH];
  int m_cph [NCH];
  int m_cam [NCH];
  int m_csh [NCH];
  bit m_vld;
  int m_hold;
  bit m_hdir;

  typedef struct {
    logic       up;
    logic       dn;
    logic [1:0] sp;
    logic       ch;
    logic       rdy;
    logic       vld;
    int         p0, p1, a0, a1, s0, s1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic up, logic dn, logic [1:0] sp, logic ch, logic rdy,
                              logic vld, int p0, int p1, int a0, int a1, int s0, int s1);
    vec_t v;
    v.up = up; v.dn = dn; v.sp = sp; v.ch = ch; v.rdy = rdy; v.vld = vld;
    v.p0 = p0; v.p1 = p1; v.a0 = a0; v.a1 = a1; v.s0 = s0; v.s1 = s1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ph(int k);
    return int'(bus.phase_M[k*PW +: PW]);
  endfunction
  function automatic int am(int k);
    return int'(bus.signal_A[k*AW +: AW]);
  endfunction
  function automatic int sh(int k);
    return int'(bus.signal_shape[k*2 +: 2]);
  endfunction

  task automatic set(logic up, logic dn, logic [1:0] sp, int ch, logic rdy);
    bus.btn_up    = up;
    bus.btn_down  = dn;
    bus.sel_param = sp;
    bus.sel_ch    = 1'(ch);
    bus.upd_ready = rdy;
  endtask

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // One clock of the reference, using the inputs the DUT sees at the coming edge.
  task automatic model_step();
    bit act, step, chg, acc, up;
    int sp, ch, old, nv;
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        m_wph[k] = PDEF; m_wam[k] = ADEF; m_wsh[k] = 0;
        m_cph[k] = PDEF; m_cam[k] = ADEF; m_csh[k] = 0;
      end
      m_vld  = 1'b0;
      m_hold = -1;
      m_hdir = 1'b0;
      return;
    end
    up   = bus.btn_up;
    act  = bus.btn_up ^ bus.btn_down;
    step = 1'b0;
    if (m_hold < 0) begin
      if (act) begin
        step   = 1'b1;
        m_hold = 0;
        m_hdir = up;
      end
    end else if (!act || (up != m_hdir)) begin
      m_hold = -1;
    end else begin
      m_hold++;
      if (m_hold == RD || (m_hold > RD && ((m_hold - RD) % RP) == 0)) step = 1'b1;
    end
    acc = m_vld && bus.upd_ready;
    if (acc) begin
      m_cph = m_wph;
      m_cam = m_wam;
      m_csh = m_wsh;
    end
    chg = 1'b0;
    sp  = int'(bus.sel_param);
    ch  = int'(bus.sel_ch);
    if (step && ch < NCH && sp != 3) begin
      old = 0;
      nv  = 0;
      case (sp)
        0: begin old = m_wph[ch]; nv = clamp(old + (up ? PSTEP : -PSTEP), 0, PMAX); m_wph[ch] = nv; end
        1: begin old = m_wam[ch]; nv = clamp(old + (up ? ASTEP : -ASTEP), 0, AMAX); m_wam[ch] = nv; end
        default: begin old = m_wsh[ch]; nv = up ? (old + 1) % 3 : (old + 2) % 3; m_wsh[ch] = nv; end
      endcase
      chg = (nv != old);
    end
    m_vld = chg || (m_vld && !acc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(string name, logic vld, int p0, int p1, int a0, int a1, int s0, int s1);
    chk({name, ".vld"}, 32'(bus.upd_valid), 32'(vld));
    chk({name, ".ph0"}, ph(0), p0);
    chk({name, ".ph1"}, ph(1), p1);
    chk({name, ".a0"},  am(0), a0);
    chk({name, ".a1"},  am(1), a1);
    chk({name, ".sh0"}, sh(0), s0);
    chk({name, ".sh1"}, sh(1), s1);
  endtask

  task automatic check_model(string name);
    chk({name, ".vld"}, 32'(bus.upd_valid), 32'(m_vld));
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("%s.ph%0d", name, k), ph(k), m_cph[k]);
      chk($sformatf("%s.a%0d", name, k),  am(k), m_cam[k]);
      chk($sformatf("%s.sh%0d", name, k), sh(k), m_csh[k]);
    end
  endtask

  initial begin
    int seq [6];
    int prev;
    int seglen, pat;
    seq = '{2, 1, 0, 2, 1, 0};

    // Reset, ready held low.
    rst = 1'b1;
    set(0, 0, 0, 0, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tick();
    check_out("reset", 0, 500, 500, 1200, 1200, 0, 0);

    // Directed vectors: single phase step + accept, ignored field, both buttons, shape cycle.
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 500, 500, 1200, 1200, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 500, 510, 1200, 1200, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 500, 510, 1200, 1200, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 500, 510, 1200, 1200, 0, 0));
    tbl.push_back(mk(0, 0, 3, 0, 0, 0, 500, 510, 1200, 1200, 0, 0));
    tbl.push_back(mk(1, 1, 2, 0, 1, 0, 500, 510, 1200, 1200, 0, 0));
    tbl.push_back(mk(0, 0, 2, 0, 1, 0, 500, 510, 1200, 1200, 0, 0));
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      tbl.push_back(mk(0, 1, 2, 0, 1, 1, 500, 510, 1200, 1200, prev, 0));
      tbl.push_back(mk(0, 0, 2, 0, 1, 0, 500, 510, 1200, 1200, seq[i], 0));
      prev = seq[i];
    end
    for (int i = 0; i < tbl.size(); i++) begin
      set(tbl[i].up, tbl[i].dn, tbl[i].sp, int'(tbl[i].ch), tbl[i].rdy);
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].vld, tbl[i].p0, tbl[i].p1,
                tbl[i].a0, tbl[i].a1, tbl[i].s0, tbl[i].s1);
    end

    // 30-cycle hold on ch0 amplitude: 7 steps, committed value frozen until ready.
    set(1, 0, SEL_AMP, 0, 0);
    repeat (30) tick();
    chk("hold.vld", 32'(bus.upd_valid), 1);
    chk("hold.a0_frozen", am(0), 1200);
    set(0, 0, SEL_AMP, 0, 1);
    tick();
    chk("hold.a0", am(0), 1550);
    chk("hold.vld_clr", 32'(bus.upd_valid), 0);

    // Amplitude up to 2000, then clamp at AMP_MAX, then a no-change step.
    repeat (9) begin
      set(1, 0, SEL_AMP, 0, 0); tick();
      set(0, 0, SEL_AMP, 0, 1); tick();
    end
    chk("amp.2000", am(0), 2000);
    set(1, 0, SEL_AMP, 0, 0); tick();
    chk("amp.clamp_vld", 32'(bus.upd_valid), 1);
    set(0, 0, SEL_AMP, 0, 1); tick();
    chk("amp.clamp", am(0), 2047);
    set(1, 0, SEL_AMP, 0, 0); tick();
    chk("amp.sat_novld", 32'(bus.upd_valid), 0);
    set(0, 0, SEL_AMP, 0, 1); tick();
    chk("amp.sat_hold", am(0), 2047);

    // Phase down to 0, then a further down step changes nothing.
    repeat (50) begin
      set(0, 1, SEL_PHASE, 0, 0); tick();
      set(0, 0, SEL_PHASE, 0, 1); tick();
    end
    chk("ph.zero", ph(0), 0);
    set(0, 1, SEL_PHASE, 0, 0); tick();
    chk("ph.floor_novld", 32'(bus.upd_valid), 0);
    set(0, 0, SEL_PHASE, 0, 1); tick();
    chk("ph.floor", ph(0), 0);

    // Accept and a changing step in the same cycle.
    set(1, 0, SEL_AMP, 1, 0); tick();
    set(0, 0, SEL_AMP, 1, 0); tick();
    chk("same.pend", 32'(bus.upd_valid), 1);
    chk("same.a1_old", am(1), 1200);
    set(1, 0, SEL_AMP, 1, 1); tick();
    chk("same.a1_snap", am(1), 1250);
    chk("same.vld_kept", 32'(bus.upd_valid), 1);
    set(0, 0, SEL_AMP, 1, 1); tick();
    chk("same.a1_new", am(1), 1300);
    chk("same.vld_clr", 32'(bus.upd_valid), 0);

    // Reset while auto-repeating; button stays held so an IDLE FSM steps at once.
    set(1, 0, SEL_PHASE, 1, 0);
    repeat (14) tick();
    chk("rpt.pend", 32'(bus.upd_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rst_mid", 0, 500, 500, 1200, 1200, 0, 0);
    tick();
    chk("rst_mid.idle_step", 32'(bus.upd_valid), 1);
    set(0, 0, SEL_PHASE, 1, 1); tick();
    chk("rst_mid.ph1", ph(1), 510);
    check_model("sync");

    // Randomized traffic against the reference model.
    for (int s = 0; s < 300; s++) begin
      seglen = $urandom_range(1, 16);
      pat    = $urandom_range(0, 3);
      set(pat == 1, pat == 2 || pat == 3 ? 1'b1 : 1'b0 , 2'($urandom_range(0, 3)),
          $urandom_range(0, 1), 1'b0);
      if (pat == 3) bus.btn_up = 1'b1;
      for (int c = 0; c < seglen; c++) begin
        bus.upd_ready = ($urandom_range(0, 9) < 3);
        if ($urandom_range(0, 15) == 0) bus.sel_param = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) bus.sel_ch = 1'($urandom_range(0, 1));
        rst = ($urandom_range(0, 399) == 0);
        tick();
        check_model($sformatf("rnd%0d_%0d", s, c));
      end
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
